// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : vec_pkg
//  Description : Shared definitions for the vector issue sequencer. Holds the
//                CFU opcode values, the ALU result-bus select encodings, the
//                sequencer FSM state type and the illegal-opcode response word.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

  // CFU opcodes carried in function_id[9:5]
  localparam logic [4:0] OP_VSETVLI = 5'h17;
  localparam logic [4:0] OP_VLOAD   = 5'h07;
  localparam logic [4:0] OP_VADDI   = 5'h15;
  localparam logic [4:0] OP_VMUL    = 5'h04;
  localparam logic [4:0] OP_VACC    = 5'h0D;
  localparam logic [4:0] OP_VBACC   = 5'h1D;

  // Result-bus select driven to the datapath during a beat
  localparam logic [1:0] BUS_LOAD  = 2'b00;  // load data / plain accumulate
  localparam logic [1:0] BUS_VADDI = 2'b01;
  localparam logic [1:0] BUS_VMUL  = 2'b10;
  localparam logic [1:0] BUS_VBACC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Response word returned for an unrecognised opcode
  localparam logic [31:0] ILLEGAL_RSP = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/vec_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : vec_op_decode
//  Description : Combinational opcode classifier for the vector issue
//                sequencer.
//  Ports       : opcode       in  5  function_id[9:5]
//                is_multibeat out 1  op expands into ceil(vl/LANES) beats
//                is_reduction out 1  op accumulates red_data into the response
//                bus_sel      out 2  result-bus select for the op's beats
//                alu_op1_sel  out 1  1 = immediate operand, 0 = vreg operand
//                writes_reg   out 1  op strobes reg_load on each beat
//                legal        out 1  opcode is recognised
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_op_decode
  import vec_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       is_multibeat,
  output logic       is_reduction,
  output logic [1:0] bus_sel,
  output logic       alu_op1_sel,
  output logic       writes_reg,
  output logic       legal
);

  always_comb begin
    is_multibeat = 1'b0;
    is_reduction = 1'b0;
    bus_sel      = BUS_LOAD;
    alu_op1_sel  = 1'b0;
    writes_reg   = 1'b0;
    legal        = 1'b1;
    case (opcode)
      OP_VSETVLI: ;
      OP_VLOAD: begin
        writes_reg = 1'b1;
      end
      OP_VADDI: begin
        is_multibeat = 1'b1;
        bus_sel      = BUS_VADDI;
        alu_op1_sel  = 1'b1;
        writes_reg   = 1'b1;
      end
      OP_VMUL: begin
        is_multibeat = 1'b1;
        bus_sel      = BUS_VMUL;
        writes_reg   = 1'b1;
      end
      OP_VACC: begin
        is_multibeat = 1'b1;
        is_reduction = 1'b1;
      end
      OP_VBACC: begin
        is_multibeat = 1'b1;
        is_reduction = 1'b1;
        bus_sel      = BUS_VBACC;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/vec_issue_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vec_issue_sequencer
//  Description : Sequential CFU vector decoder. Accepts one command at a time,
//                holds the vector length, expands vector ops into per-beat
//                regfile/ALU control, accumulates reductions and returns one
//                response per command.
//  Ports       : clk, reset (async, active-high)
//                cmd_valid/cmd_ready, cmd_payload_function_id/inputs_0/inputs_1
//                rsp_valid/rsp_ready, rsp_payload_outputs_0
//                reg_op0_sel/reg_op1_sel/reg_wb_sel  regfile selects
//                reg_load, elem_grp, lane_mask        per-beat regfile control
//                alu_imm, alu_op1_sel, bus_sel        per-beat ALU control
//                ld_data                              vload data
//                red_data                             per-beat reduction partial
//                vl                                   current vector length
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_issue_sequencer
  import vec_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int LANES  = 4,
  parameter  int MAX_VL = 16,
  parameter  int IMM_W  = 8,
  localparam int GRP_W  = $clog2(MAX_VL / LANES),
  localparam int VL_W   = $clog2(MAX_VL) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_payload_function_id,
  input  logic [DATA_W-1:0] cmd_payload_inputs_0,
  input  logic [DATA_W-1:0] cmd_payload_inputs_1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_payload_outputs_0,
  output logic [4:0]        reg_op0_sel,
  output logic [4:0]        reg_op1_sel,
  output logic [4:0]        reg_wb_sel,
  output logic              reg_load,
  output logic [GRP_W-1:0]  elem_grp,
  output logic [LANES-1:0]  lane_mask,
  output logic [IMM_W-1:0]  alu_imm,
  output logic              alu_op1_sel,
  output logic [1:0]        bus_sel,
  output logic [DATA_W-1:0] ld_data,
  input  logic [DATA_W-1:0] red_data,
  output logic [VL_W-1:0]   vl
);

  localparam int LG_LANES = $clog2(LANES);

  state_t             r_state;
  logic [VL_W-1:0]    r_vl;
  logic [DATA_W-1:0]  r_acc;
  logic [GRP_W-1:0]   r_last_grp;
  logic               r_is_red;

  logic [4:0]         w_opcode;
  logic               w_is_multibeat;
  logic               w_is_reduction;
  logic [1:0]         w_bus_sel;
  logic               w_alu_op1_sel;
  logic               w_writes_reg;
  logic               w_legal;
  logic [VL_W-1:0]    w_new_vl;
  logic [VL_W-1:0]    w_nbeats;
  logic [GRP_W-1:0]   w_last_grp;
  logic [LG_LANES-1:0] w_part;
  logic [LANES-1:0]   w_part_mask;
  logic [GRP_W-1:0]   w_next_grp;
  logic               w_unused_bits;

  assign w_opcode = cmd_payload_function_id[9:5];
  assign vl       = r_vl;

  vec_op_decode u_decode (
    .opcode       (w_opcode),
    .is_multibeat (w_is_multibeat),
    .is_reduction (w_is_reduction),
    .bus_sel      (w_bus_sel),
    .alu_op1_sel  (w_alu_op1_sel),
    .writes_reg   (w_writes_reg),
    .legal        (w_legal)
  );

  // vsetvli clamps the requested AVL to the hardware maximum
  assign w_new_vl = (cmd_payload_inputs_0 > DATA_W'(MAX_VL)) ? VL_W'(MAX_VL)
                                                            : cmd_payload_inputs_0[VL_W-1:0];

  // Beat count ceil(vl/LANES); only meaningful for vl != 0
  assign w_nbeats    = VL_W'((r_vl + VL_W'(LANES - 1)) >> LG_LANES);
  assign w_last_grp  = GRP_W'(w_nbeats - VL_W'(1));
  assign w_part      = r_vl[LG_LANES-1:0];
  assign w_part_mask = LANES'((32'd1 << w_part) - 32'd1);
  assign w_next_grp  = elem_grp + GRP_W'(1);

  // Upper rs2 bits carry no information for any opcode
  assign w_unused_bits = ^cmd_payload_inputs_1[DATA_W-1:IMM_W];

  // Lanes for a given group: the final group is partial when vl is not a
  // multiple of LANES
  function automatic logic [LANES-1:0] beat_mask(input logic [GRP_W-1:0] grp,
                                                 input logic [GRP_W-1:0] last,
                                                 input logic [LG_LANES-1:0] part,
                                                 input logic [LANES-1:0] part_mask);
    if (grp == last && part != '0) return part_mask;
    return '1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state               <= ST_IDLE;
      r_vl                  <= '0;
      r_acc                 <= '0;
      r_last_grp            <= '0;
      r_is_red              <= 1'b0;
      cmd_ready             <= 1'b1;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      reg_op0_sel           <= '0;
      reg_op1_sel           <= '0;
      reg_wb_sel            <= '0;
      reg_load              <= 1'b0;
      elem_grp              <= '0;
      lane_mask             <= '0;
      alu_imm               <= '0;
      alu_op1_sel           <= 1'b0;
      bus_sel               <= '0;
      ld_data               <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready   <= 1'b0;
            reg_op0_sel <= cmd_payload_inputs_0[4:0];
            reg_op1_sel <= cmd_payload_inputs_1[4:0];
            reg_wb_sel  <= cmd_payload_function_id[4:0];
            r_acc       <= '0;
            r_is_red    <= w_is_reduction;
            if (!w_legal) begin
              rsp_payload_outputs_0 <= DATA_W'(ILLEGAL_RSP);
              rsp_valid             <= 1'b1;
              r_state               <= ST_RESP;
            end else if (w_opcode == OP_VSETVLI) begin
              r_vl                  <= w_new_vl;
              rsp_payload_outputs_0 <= DATA_W'(w_new_vl);
              rsp_valid             <= 1'b1;
              r_state               <= ST_RESP;
            end else if (w_opcode == OP_VLOAD || r_vl != '0) begin
              // Per-command ALU controls are latched here and held for every beat
              r_state     <= ST_ISSUE;
              reg_load    <= w_writes_reg;
              bus_sel     <= w_bus_sel;
              alu_op1_sel <= w_alu_op1_sel;
              alu_imm     <= cmd_payload_inputs_1[IMM_W-1:0];
              if (w_opcode == OP_VLOAD) begin
                // Single beat at the group named by rs2
                elem_grp   <= cmd_payload_inputs_1[GRP_W-1:0];
                r_last_grp <= cmd_payload_inputs_1[GRP_W-1:0];
                lane_mask  <= '1;
                ld_data    <= cmd_payload_inputs_0;
              end else begin
                elem_grp   <= '0;
                r_last_grp <= w_last_grp;
                lane_mask  <= beat_mask('0, w_last_grp, w_part, w_part_mask);
              end
            end else begin
              // Vector op with vl=0: nothing to issue, respond immediately
              rsp_payload_outputs_0 <= '0;
              rsp_valid             <= 1'b1;
              r_state               <= ST_RESP;
            end
          end
        end

        ST_ISSUE: begin
          if (r_is_red) r_acc <= r_acc + red_data;
          if (elem_grp == r_last_grp) begin
            // Include the final beat's partial sum in the response directly
            rsp_payload_outputs_0 <= r_is_red ? (r_acc + red_data) : '0;
            rsp_valid             <= 1'b1;
            r_state               <= ST_RESP;
            reg_load              <= 1'b0;
            elem_grp              <= '0;
            lane_mask             <= '0;
            alu_imm               <= '0;
            alu_op1_sel           <= 1'b0;
            bus_sel               <= '0;
            ld_data               <= '0;
          end else begin
            elem_grp  <= w_next_grp;
            lane_mask <= beat_mask(w_next_grp, r_last_grp, w_part, w_part_mask);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid             <= 1'b0;
            rsp_payload_outputs_0 <= '0;
            cmd_ready             <= 1'b1;
            r_state               <= ST_IDLE;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_issue_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_issue_sequencer
//  Description : Self-checking bench for vec_issue_sequencer. Directed command
//                sequences followed by random commands, each compared against
//                a command-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_issue_sequencer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  function_id;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  op0_sel;
  logic [4:0]  op1_sel;
  logic [4:0]  wb_sel;
  logic        reg_load;
  logic [1:0]  elem_grp;
  logic [3:0]  lane_mask;
  logic [7:0]  alu_imm;
  logic        alu_op1_sel;
  logic [1:0]  bus_sel;
  logic [31:0] ld_data;
  logic [31:0] red_data;
  logic [4:0]  vl;

  vec_issue_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (function_id),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data),
    .reg_op0_sel             (op0_sel),
    .reg_op1_sel             (op1_sel),
    .reg_wb_sel              (wb_sel),
    .reg_load                (reg_load),
    .elem_grp                (elem_grp),
    .lane_mask               (lane_mask),
    .alu_imm                 (alu_imm),
    .alu_op1_sel             (alu_op1_sel),
    .bus_sel                 (bus_sel),
    .ld_data                 (ld_data),
    .red_data                (red_data),
    .vl                      (vl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_vl     = 0;    // model vector length
  logic [31:0] red_q[$];        // directed reduction partials, else random

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit known_op(input logic [4:0] op);
    return op == 5'h17 || op == 5'h07 || op == 5'h15 || op == 5'h04 ||
           op == 5'h0D || op == 5'h1D;
  endfunction

  // Issue one command starting at a negedge in IDLE, check every beat and the
  // response, hold rsp_ready low for 'stall' cycles, then complete it.
  task automatic run_cmd(input logic [9:0] f, input logic [31:0] a,
                         input logic [31:0] b, input int stall);
    logic [4:0]  op;
    int          nb;
    int          part;
    bit          red;
    bit          wr;
    bit          imm_sel;
    logic [1:0]  bus;
    logic [31:0] exp_rsp;
    logic [31:0] sum;
    logic [31:0] rd;
    logic [3:0]  emask;
    logic [1:0]  egrp;

    op = f[9:5];
    nb = 0; red = 0; wr = 0; imm_sel = 0; bus = 2'd0; exp_rsp = 32'd0; sum = 32'd0;
    case (op)
      5'h17: exp_rsp = (a > 32'd16) ? 32'd16 : a;
      5'h07: begin nb = 1; wr = 1; end
      5'h15: begin nb = (m_vl + 3) / 4; wr = 1; bus = 2'd1; imm_sel = 1; end
      5'h04: begin nb = (m_vl + 3) / 4; wr = 1; bus = 2'd2; end
      5'h0D: begin nb = (m_vl + 3) / 4; red = 1; bus = 2'd0; end
      5'h1D: begin nb = (m_vl + 3) / 4; red = 1; bus = 2'd3; end
      default: exp_rsp = 32'hFFFF_FFFF;
    endcase
    part = m_vl % 4;

    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; function_id = f; in0 = a; in1 = b;
    @(negedge clk);
    cmd_valid = 1'b0; function_id = 10'($urandom); in0 = $urandom; in1 = $urandom;

    for (int k = 0; k < nb; k++) begin
      egrp  = (op == 5'h07) ? b[1:0] : 2'(k);
      emask = (op != 5'h07 && k == nb - 1 && part != 0) ? 4'((1 << part) - 1) : 4'hF;
      chk("beat_reg_load", reg_load, wr);
      chk("beat_elem_grp", elem_grp, egrp);
      chk("beat_lane_mask", lane_mask, emask);
      chk("beat_bus_sel", bus_sel, bus);
      chk("beat_op1_sel", alu_op1_sel, imm_sel);
      chk("beat_alu_imm", alu_imm, b[7:0]);
      if (op == 5'h07) chk("beat_ld_data", ld_data, a);
      chk("beat_rsp_valid", rsp_valid, 0);
      chk("beat_cmd_ready", cmd_ready, 0);
      chk("beat_wb_sel", wb_sel, f[4:0]);
      chk("beat_op0_sel", op0_sel, a[4:0]);
      chk("beat_op1_sel_reg", op1_sel, b[4:0]);
      rd = (red_q.size() > 0) ? red_q.pop_front() : $urandom;
      red_data = rd;
      if (red) sum = sum + rd;
      @(negedge clk);
    end
    red_data = $urandom;
    if (red) exp_rsp = sum;
    if (op == 5'h17) m_vl = int'(exp_rsp);

    for (int s = 0; s <= stall; s++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, exp_rsp);
      chk("rsp_cmd_ready", cmd_ready, 0);
      chk("rsp_reg_load", reg_load, 0);
      chk("rsp_lane_mask", lane_mask, 0);
      chk("rsp_bus_sel", bus_sel, 0);
      chk("rsp_wb_sel", wb_sel, f[4:0]);
      if (s < stall) begin
        // A command offered while the response is pending must be ignored
        cmd_valid = 1'($urandom_range(0, 1));
        function_id = 10'($urandom);
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_rsp_data", rsp_data, 0);
    chk("done_vl", vl, m_vl);
  endtask

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra;
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    function_id = '0; in0 = '0; in1 = '0; red_data = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_reg_load", reg_load, 0);
    chk("rst_elem_grp", elem_grp, 0);
    chk("rst_lane_mask", lane_mask, 0);
    chk("rst_alu_imm", alu_imm, 0);
    chk("rst_op1_sel", alu_op1_sel, 0);
    chk("rst_bus_sel", bus_sel, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_vl", vl, 0);
    chk("rst_wb_sel", wb_sel, 0);
    reset = 1'b0;
    @(negedge clk);

    // vsetvli clamping then exact value
    run_cmd({5'h17, 5'd0}, 32'd40, 32'd0, 0);
    chk("vl_clamped", vl, 16);
    run_cmd({5'h17, 5'd0}, 32'd6, 32'd0, 0);

    // vaddi at vl=6: full beat then partial beat
    run_cmd({5'h15, 5'd3}, 32'd1, 32'h05, 0);

    // vacc at vl=16 with wrapping sum
    run_cmd({5'h17, 5'd0}, 32'd16, 32'd0, 0);
    red_q = '{32'h10, 32'h20, 32'h30, 32'hFFFF_FFF0};
    run_cmd({5'h0D, 5'd7}, 32'd0, 32'd0, 0);

    // Response back-pressure for 5 cycles
    run_cmd({5'h04, 5'd1}, 32'd2, 32'd3, 5);

    // vl=0 vector op, then illegal opcode leaves vl alone
    run_cmd({5'h17, 5'd0}, 32'd0, 32'd0, 0);
    run_cmd({5'h04, 5'd2}, 32'd4, 32'd5, 0);
    run_cmd({5'h1D, 5'd2}, 32'd4, 32'd5, 1);
    run_cmd({5'h17, 5'd0}, 32'd6, 32'd0, 0);
    run_cmd({5'h1F, 5'd9}, 32'd1, 32'd2, 2);
    run_cmd({5'h07, 5'd4}, 32'hDEAD_BEEF, 32'h0000_0002, 0);

    // Reset during the second beat of vmul
    run_cmd({5'h17, 5'd0}, 32'd16, 32'd0, 0);
    cmd_valid = 1'b1; function_id = {5'h04, 5'd2}; in0 = 32'd1; in1 = 32'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_beat_reg_load", reg_load, 1);
    chk("mid_beat_elem_grp", elem_grp, 1);
    reset = 1'b1;
    #1;
    m_vl = 0;
    chk("async_rst_cmd_ready", cmd_ready, 1);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_reg_load", reg_load, 0);
    chk("async_rst_vl", vl, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 0);
      chk("post_rst_no_load", reg_load, 0);
    end
    run_cmd({5'h04, 5'd2}, 32'd1, 32'd2, 0);

    // Random command stream
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0: rop = 5'h17;
        1: rop = 5'h07;
        2: rop = 5'h15;
        3: rop = 5'h04;
        4: rop = 5'h0D;
        5: rop = 5'h1D;
        default: begin
          rop = 5'($urandom_range(0, 31));
          while (known_op(rop)) rop = 5'($urandom_range(0, 31));
        end
      endcase
      ra = (rop == 5'h17) ? 32'($urandom_range(0, 40)) : $urandom;
      run_cmd({rop, 5'($urandom_range(0, 31))}, ra, $urandom, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
